// File: rtl/result_reader_pkg.sv
// Shared definitions for the detection result reader.
//   Holds default widths, the reader FSM state encoding, the record word slot
//   indices and the statistics counter width. No ports.
package result_pkg;

  localparam int unsigned DATA_WIDTH_12 = 12;
  localparam int unsigned NUM_RESIZE    = 5;
  localparam int unsigned SCALE_W       = 3;
  localparam int unsigned NUM_VARIABLE  = 3;
  localparam int unsigned IDX_W         = 2;
  localparam int unsigned STAT_W        = 16;

  typedef enum logic [1:0] {
    REQ = 2'd0,
    CAP = 2'd1,
    OUT = 2'd2
  } state_e;

  typedef logic [IDX_W-1:0] idx_t;

  // Word order inside one record as it leaves the FIFO
  localparam idx_t IDX_X    = 2'd0;
  localparam idx_t IDX_Y    = 2'd1;
  localparam idx_t IDX_CAND = 2'd2;

endpackage

// File: rtl/result_reader_if.sv
// Bus bundle between the result FIFO, the reader and the overlay consumer.
//   i_result/i_empty/o_read_result : FIFO read side (q, empty, rdreq)
//   o_valid/i_ready                : record handshake towards the consumer
//   o_x/o_y/o_candidate            : reassembled record
//   o_scale/o_multi_scale          : decoded candidate mask
// Modports: master = the reader, slave = FIFO plus consumer environment.
interface result_reader_if #(
  parameter int unsigned DATA_WIDTH_12 = result_pkg::DATA_WIDTH_12,
  parameter int unsigned NUM_RESIZE    = result_pkg::NUM_RESIZE,
  parameter int unsigned SCALE_W       = result_pkg::SCALE_W
);

  logic [DATA_WIDTH_12-1:0] i_result;
  logic                     i_empty;
  logic                     o_read_result;
  logic                     o_valid;
  logic                     i_ready;
  logic [DATA_WIDTH_12-1:0] o_x;
  logic [DATA_WIDTH_12-1:0] o_y;
  logic [NUM_RESIZE-1:0]    o_candidate;
  logic [SCALE_W-1:0]       o_scale;
  logic                     o_multi_scale;

  modport master (
    input  i_result, i_empty, i_ready,
    output o_read_result, o_valid, o_x, o_y, o_candidate, o_scale, o_multi_scale
  );

  modport slave (
    output i_result, i_empty, i_ready,
    input  o_read_result, o_valid, o_x, o_y, o_candidate, o_scale, o_multi_scale
  );

endinterface

// File: rtl/result_reader_scale_decode.sv
// Candidate mask decoder (purely combinational).
//   mask_i  : one bit per resize level
//   scale_o : index of the lowest set bit (0 when the mask is empty)
//   multi_o : more than one bit set
module scale_decode
  import result_pkg::*;
#(
  parameter int unsigned NUM_RESIZE = result_pkg::NUM_RESIZE,
  parameter int unsigned SCALE_W    = result_pkg::SCALE_W
) (
  input  logic [NUM_RESIZE-1:0] mask_i,
  output logic [SCALE_W-1:0]    scale_o,
  output logic                  multi_o
);

  // Scan from the top so the last hit wins, leaving the lowest set index
  always_comb begin
    scale_o = '0;
    for (int i = int'(NUM_RESIZE) - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        scale_o = SCALE_W'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves something only if a second bit exists
  assign multi_o = |(mask_i & (mask_i - NUM_RESIZE'(1)));

endmodule

// File: rtl/result_reader.sv
// Detection result reader.
//   Drains 12-bit words from the result FIFO, regroups them into face records
//   (x, y, candidate mask), drops records with an empty mask and presents each
//   record with its decoded scale on a valid/ready handshake.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   bus (master)        : FIFO read side + record output, see result_reader_if
//   o_face_count        : accepted records, saturating  (RESULT_STATS_EN only)
//   o_drop_count        : zero-mask drops, saturating   (RESULT_STATS_EN only)
// Build option: define RESULT_STATS_EN to add the two statistics counters.
module result_reader #(
  parameter int unsigned DATA_WIDTH_12 = result_pkg::DATA_WIDTH_12,
  parameter int unsigned NUM_RESIZE    = result_pkg::NUM_RESIZE,
  parameter int unsigned SCALE_W       = result_pkg::SCALE_W
) (
  input  logic              clk,
  input  logic              reset,
  result_reader_if.master   bus
`ifdef RESULT_STATS_EN
  ,
  output logic [15:0]       o_face_count,
  output logic [15:0]       o_drop_count
`endif
);

  import result_pkg::*;

  state_e                   state_q;
  idx_t                     idx_q;
  logic [DATA_WIDTH_12-1:0] x_q;
  logic [DATA_WIDTH_12-1:0] y_q;
  logic [NUM_RESIZE-1:0]    cand_q;
  logic [SCALE_W-1:0]       scale_q;
  logic                     multi_q;
  logic                     valid_q;

  logic [NUM_RESIZE-1:0]    cand_d;
  logic [SCALE_W-1:0]       scale_d;
  logic                     multi_d;

  // Upper bits of the candidate word carry no meaning
  assign cand_d = bus.i_result[NUM_RESIZE-1:0];

  scale_decode #(
    .NUM_RESIZE (NUM_RESIZE),
    .SCALE_W    (SCALE_W)
  ) u_scale_decode (
    .mask_i  (cand_d),
    .scale_o (scale_d),
    .multi_o (multi_d)
  );

  // Read request must land in the same cycle as the empty check; gated by reset
  // so nothing is popped while the record state is being cleared.
  assign bus.o_read_result = (state_q == REQ) && !bus.i_empty && !reset;

  assign bus.o_valid       = valid_q;
  assign bus.o_x           = x_q;
  assign bus.o_y           = y_q;
  assign bus.o_candidate   = cand_q;
  assign bus.o_scale       = scale_q;
  assign bus.o_multi_scale = multi_q;

  // Reader FSM: one word per REQ/CAP pair, hold the record in OUT
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= REQ;
      idx_q   <= IDX_X;
      x_q     <= '0;
      y_q     <= '0;
      cand_q  <= '0;
      scale_q <= '0;
      multi_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        REQ: begin
          if (!bus.i_empty) begin
            state_q <= CAP;
          end
        end
        CAP: begin
          state_q <= REQ;
          case (idx_q)
            IDX_X: begin
              x_q   <= bus.i_result;
              idx_q <= IDX_Y;
            end
            IDX_Y: begin
              y_q   <= bus.i_result;
              idx_q <= IDX_CAND;
            end
            default: begin
              cand_q <= cand_d;
              idx_q  <= IDX_X;
              // An empty mask means no detection: drop silently, keep reading
              if (cand_d != '0) begin
                state_q <= OUT;
                valid_q <= 1'b1;
                scale_q <= scale_d;
                multi_q <= multi_d;
              end
            end
          endcase
        end
        OUT: begin
          if (bus.i_ready) begin
            state_q <= REQ;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= REQ;
        end
      endcase
    end
  end

`ifdef RESULT_STATS_EN
  logic [15:0] face_q;
  logic [15:0] drop_q;
  logic        accept_c;
  logic        drop_c;

  assign accept_c = valid_q && bus.i_ready;
  assign drop_c   = (state_q == CAP) && (idx_q == IDX_CAND) && (cand_d == '0);

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      face_q <= '0;
      drop_q <= '0;
    end else begin
      if (accept_c && (face_q != 16'hFFFF)) begin
        face_q <= face_q + 16'd1;
      end
      if (drop_c && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
    end
  end

  assign o_face_count = face_q;
  assign o_drop_count = drop_q;
`endif

endmodule
